wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writeback stage directly upstream of the register file write port.
- Merges ALU results (valid/ready handshake) and memory load returns (no backpressure) onto the single regfile write port (rw/rd/din).
- Buffers loads in a small FIFO and preserves write-after-write order per destination register.
- Discards writes to x0.

Parameters:
- LD_DEPTH, 4: load FIFO entries; power of two, at least 2.
- CNT_W, 3: width of ld_count; must equal clog2(LD_DEPTH+1).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU result valid
- alu_ready  out  1  ALU result accepted this cycle when alu_valid & alu_ready
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- ld_valid  in  1  load return valid; always accepted, no ready
- ld_rd  in  5  load destination register
- ld_data  in  32  load data
- ld_full  out  1  FIFO holds LD_DEPTH entries (status only)
- ld_count  out  CNT_W  current FIFO occupancy
- rf_rw  out  1  regfile write enable
- rf_rd  out  5  regfile write address
- rf_din  out  32  regfile write data

Behaviour:
- Reset (reset=0, async): FIFO emptied, pointers/count=0, rf_rw=0, rf_rd=0, rf_din=0. alu_ready reflects the empty FIFO (1).
- rf_rw/rf_rd/rf_din are registered. At most one write is issued per cycle.
- Each cycle, select one source in priority order:
  - a) Force-drain: FIFO head if count==LD_DEPTH, or if alu_valid and alu_rd!=0 and alu_rd matches the rd of any occupied FIFO entry (WAW guard).
  - b) Otherwise ALU, if alu_valid.
  - c) Otherwise FIFO head, if count>0.
  - d) Otherwise incoming load, passed straight through when the FIFO is empty and ld_valid=1 (no push).
  - e) Otherwise idle: rf_rw=0 next cycle; rf_rd/rf_din hold their values.
- alu_ready is combinational from registered state and alu_rd: 1 unless case (a) applies.
- Load push: if ld_valid=1, ld_rd!=0 and the load is not taken by the case (d) bypass, push at the tail.
  - A push at count==LD_DEPTH is always legal, because case (a) pops the same cycle.
  - Loads can never be dropped.
- Loads with ld_rd==0 are discarded outright: no push, no write.
- ALU results with alu_rd==0 are accepted (handshake completes) but produce rf_rw=0.
- Latency:
  - ALU accepted at cycle N gives rf_rw=1 at N+1.
  - Bypassed load: N+1.
  - Buffered load: at least N+2.
- Same-cycle ALU accept and load push to the same rd: the load is treated as younger, so the ALU write lands first and the load overwrites it later.
- Count: push-only +1, pop-only -1, push+pop unchanged. Pointers wrap modulo LD_DEPTH.
- ld_full = (count==LD_DEPTH).
- Reset asserted mid-operation discards all buffered loads. Any ALU handshake in that cycle is lost.

Optional Feature:
- Macro: WB_FWD_EN.
- When defined, add ports:
  - rs1, rs2 in 5
  - fwd1_hit, fwd2_hit out 1
  - fwd1_data, fwd2_data out 32
- fwdX_hit = rf_rw & (rf_rd==rsX) & (rsX!=0); fwdX_data = rf_din when hit, else 0. Both are combinational.
- This covers the cycle in which the regfile has not yet absorbed the write.
- When undefined, these ports and their logic are absent, and all other behaviour is identical.

Test Plan:
- Reset: hold reset=0 with random inputs → rf_rw=0, rf_rd=0, rf_din=0, ld_count=0, alu_ready=1. Release reset: no write until the first valid input.
- ALU only: alu_valid=1, rd=5, data=0xDEADBEEF at cycle N → cycle N+1: rf_rw=1, rf_rd=5, rf_din=0xDEADBEEF.
- Collision: FIFO empty; ALU rd=3 data=0x11 and load rd=4 data=0x22 in the same cycle N →
  - N+1: write rd3=0x11, ld_count=1.
  - N+2: write rd4=0x22, ld_count=0.
- Fill: ALU streams distinct rds 8..15 while loads rd 16..20 arrive back-to-back, LD_DEPTH=4 →
  - ld_count reaches 4 and ld_full=1.
  - alu_ready drops to 0; the FIFO pops one per cycle.
  - All 5 loads are written in order and none are lost.
- WAW: load rd=7 data=0xA buffered behind ALU traffic, then ALU rd=7 data=0xB →
  - alu_ready=0 until the rd7 load is written.
  - The ALU write follows; the final value of rd7 is 0xB.
- x0 and reset: load rd=0 → no push, no write. ALU rd=0 → handshake completes, rf_rw=0. Assert reset with ld_count=3 → count=0 immediately, with no buffered write after release.

Source files
------------

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter merging ALU results and buffered load returns onto the regfile port
// Optional operand forwarding ports are enabled by defining WB_FWD_EN.
module wb_arbiter #(
  parameter int LD_DEPTH = 4,
  parameter int CNT_W    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [4:0]        alu_rd,
  input  logic [31:0]       alu_data,
  input  logic              ld_valid,
  input  logic [4:0]        ld_rd,
  input  logic [31:0]       ld_data,
  output logic              ld_full,
  output logic [CNT_W-1:0]  ld_count,
  output logic              rf_rw,
  output logic [4:0]        rf_rd,
`ifdef WB_FWD_EN
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  output logic              fwd1_hit,
  output logic              fwd2_hit,
  output logic [31:0]       fwd1_data,
  output logic [31:0]       fwd2_data,
`endif
  output logic [31:0]       rf_din
);

  localparam int PW = $clog2(LD_DEPTH);

  logic [4:0]       fifo_rd_q  [LD_DEPTH];
  logic [31:0]      fifo_dat_q [LD_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rf_rw_q, rf_rw_d;
  logic [4:0]       rf_rd_q, rf_rd_d;
  logic [31:0]      rf_din_q, rf_din_d;

  logic             full, waw, force_drain, alu_take, pop, bypass, push;
  logic [PW-1:0]    offs;

  // WAW guard: an ALU write must not overtake an older buffered load to the same rd.
  always_comb begin
    waw  = 1'b0;
    offs = '0;
    for (int i = 0; i < LD_DEPTH; i++) begin
      offs = PW'(i) - rd_ptr_q;
      if ((CNT_W'(offs) < count_q) && (fifo_rd_q[i] == alu_rd)) waw = 1'b1;
    end
    waw = waw & alu_valid & (alu_rd != 5'd0);
  end

  always_comb begin
    full        = (count_q == CNT_W'(LD_DEPTH));
    force_drain = full | waw;
    alu_take    = ~force_drain & alu_valid;
    pop         = force_drain | (~alu_valid & (count_q != '0));
    bypass      = ~force_drain & ~alu_valid & (count_q == '0) & ld_valid & (ld_rd != 5'd0);
    push        = ld_valid & (ld_rd != 5'd0) & ~bypass;

    rf_rw_d  = 1'b0;
    rf_rd_d  = rf_rd_q;
    rf_din_d = rf_din_q;
    if (pop) begin
      rf_rw_d  = 1'b1;
      rf_rd_d  = fifo_rd_q[rd_ptr_q];
      rf_din_d = fifo_dat_q[rd_ptr_q];
    end else if (alu_take) begin
      if (alu_rd != 5'd0) begin
        rf_rw_d  = 1'b1;
        rf_rd_d  = alu_rd;
        rf_din_d = alu_data;
      end
    end else if (bypass) begin
      rf_rw_d  = 1'b1;
      rf_rd_d  = ld_rd;
      rf_din_d = ld_data;
    end

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rf_rw_q  <= 1'b0;
      rf_rd_q  <= 5'd0;
      rf_din_q <= 32'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rf_rw_q  <= rf_rw_d;
      rf_rd_q  <= rf_rd_d;
      rf_din_q <= rf_din_d;
    end
  end

  // At full, push and pop share a slot; the head is read combinationally before it is overwritten.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]  <= ld_rd;
      fifo_dat_q[wr_ptr_q] <= ld_data;
    end
  end

  assign alu_ready = ~force_drain;
  assign ld_full   = full;
  assign ld_count  = count_q;
  assign rf_rw     = rf_rw_q;
  assign rf_rd     = rf_rd_q;
  assign rf_din    = rf_din_q;

`ifdef WB_FWD_EN
  assign fwd1_hit  = rf_rw_q & (rf_rd_q == rs1) & (rs1 != 5'd0);
  assign fwd2_hit  = rf_rw_q & (rf_rd_q == rs2) & (rs2 != 5'd0);
  assign fwd1_data = fwd1_hit ? rf_din_q : 32'd0;
  assign fwd2_data = fwd2_hit ? rf_din_q : 32'd0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - randomized and directed self-checking bench for wb_arbiter against a queue model
module tb_wb_arbiter;
  localparam int LD_DEPTH = 4;
  localparam int CNT_W    = 3;

  logic             clk, reset;
  logic             av, lv;
  logic [4:0]       ard, lrd;
  logic [31:0]      ad, ldd;
  logic             alu_ready, ld_full, rf_rw;
  logic [CNT_W-1:0] ld_count;
  logic [4:0]       rf_rd;
  logic [31:0]      rf_din;

  wb_arbiter #(.LD_DEPTH(LD_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(av), .alu_ready(alu_ready), .alu_rd(ard), .alu_data(ad),
    .ld_valid(lv), .ld_rd(lrd), .ld_data(ldd),
    .ld_full(ld_full), .ld_count(ld_count),
    .rf_rw(rf_rw), .rf_rd(rf_rd), .rf_din(rf_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [4:0]  q_rd [$];
  logic [31:0] q_dat [$];
  logic        exp_rw, acc;
  logic [4:0]  exp_rd;
  logic [31:0] exp_din;
  logic [4:0]  wr_log [$];
  logic [31:0] rf_mirror [32];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // One clock: entered just after a negedge with inputs driven, returns at the next negedge.
  task automatic cycle();
    bit waw, frc, byp;
    #1;
    if (!reset) begin
      q_rd.delete();
      q_dat.delete();
      acc = 1'b0;
      chk("rst_ready", alu_ready, 1);
      chk("rst_count", ld_count, 0);
      chk("rst_rw", rf_rw, 0);
      chk("rst_rd", rf_rd, 0);
      chk("rst_din", rf_din, 0);
      exp_rw = 1'b0; exp_rd = 5'd0; exp_din = 32'd0;
      @(posedge clk); #1;
      chk("rst_rw_post", rf_rw, 0);
      @(negedge clk);
      return;
    end
    waw = 0;
    foreach (q_rd[i]) if (q_rd[i] == ard) waw = 1;
    waw = waw && av && (ard != 0);
    frc = (q_rd.size() == LD_DEPTH) || waw;
    chk("alu_ready", alu_ready, !frc);
    chk("ld_count", ld_count, q_rd.size());
    chk("ld_full", ld_full, q_rd.size() == LD_DEPTH);
    acc = av && !frc;
    byp = 0;
    exp_rw = 1'b0;
    if (frc || (!av && q_rd.size() > 0)) begin
      exp_rw = 1'b1; exp_rd = q_rd.pop_front(); exp_din = q_dat.pop_front();
    end else if (av) begin
      if (ard != 0) begin exp_rw = 1'b1; exp_rd = ard; exp_din = ad; end
    end else if (lv && lrd != 0) begin
      byp = 1; exp_rw = 1'b1; exp_rd = lrd; exp_din = ldd;
    end
    if (lv && lrd != 0 && !byp) begin
      q_rd.push_back(lrd);
      q_dat.push_back(ldd);
    end
    @(posedge clk); #1;
    chk("rf_rw", rf_rw, exp_rw);
    if (exp_rw) begin
      chk("rf_rd", rf_rd, exp_rd);
      chk("rf_din", rf_din, exp_din);
    end
    if (rf_rw) begin
      wr_log.push_back(rf_rd);
      rf_mirror[rf_rd] = rf_din;
    end
    @(negedge clk);
  endtask

  task automatic idle_in();
    av = 0; ard = 0; ad = 0; lv = 0; lrd = 0; ldd = 0;
  endtask

  initial begin
    int idx, li, mx, nw;
    bit saw_nr, saw_full;
    logic [4:0] lds [$];
    reset = 1'b0; idle_in();
    exp_rw = 0; exp_rd = 0; exp_din = 0; acc = 0;
    @(negedge clk);

    // reset with random inputs
    for (int i = 0; i < 3; i++) begin
      av = 1'($urandom); ard = 5'($urandom); ad = $urandom;
      lv = 1'($urandom); lrd = 5'($urandom); ldd = $urandom;
      cycle();
    end
    reset = 1'b1; idle_in();
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("post_rst_nowrite", rf_rw, 0);
    end

    // ALU only
    av = 1; ard = 5; ad = 32'hDEADBEEF;
    cycle();
    chk("alu_rw", rf_rw, 1); chk("alu_rd", rf_rd, 5); chk("alu_din", rf_din, 32'hDEADBEEF);
    idle_in();
    cycle();

    // collision
    av = 1; ard = 3; ad = 32'h11; lv = 1; lrd = 4; ldd = 32'h22;
    cycle();
    chk("col1_rd", rf_rd, 3); chk("col1_din", rf_din, 32'h11); chk("col1_cnt", ld_count, 1);
    idle_in();
    cycle();
    chk("col2_rd", rf_rd, 4); chk("col2_din", rf_din, 32'h22); chk("col2_cnt", ld_count, 0);

    // fill
    wr_log.delete();
    idx = 0; li = 0; mx = 0; saw_nr = 0; saw_full = 0;
    for (int c = 0; c < 40 && idx < 8; c++) begin
      av = 1; ard = 5'(8 + idx); ad = 32'h100 + idx;
      lv = (li < 5); lrd = 5'(16 + li); ldd = 32'h200 + li;
      if (lv) li++;
      #1;
      if (!alu_ready) saw_nr = 1;
      cycle();
      if (acc) idx++;
      if (int'(ld_count) > mx) mx = int'(ld_count);
      if (ld_full) saw_full = 1;
    end
    idle_in();
    for (int i = 0; i < 8; i++) cycle();
    chk("fill_alu_done", idx, 8);
    chk("fill_max", mx, 4);
    chk("fill_full", saw_full, 1);
    chk("fill_stall", saw_nr, 1);
    foreach (wr_log[i]) if (wr_log[i] >= 16) lds.push_back(wr_log[i]);
    chk("fill_nloads", lds.size(), 5);
    foreach (lds[i]) chk("fill_order", lds[i], 16 + i);

    // WAW
    av = 1; ard = 1; ad = 32'h1; lv = 1; lrd = 7; ldd = 32'hA;
    cycle();
    chk("waw_cnt", ld_count, 1);
    av = 1; ard = 7; ad = 32'hB; lv = 0;
    #1; chk("waw_ready0", alu_ready, 0);
    cycle();
    chk("waw_ld_rd", rf_rd, 7); chk("waw_ld_din", rf_din, 32'hA);
    #1; chk("waw_ready1", alu_ready, 1);
    cycle();
    chk("waw_alu_din", rf_din, 32'hB);
    idle_in();
    cycle();
    chk("waw_final", rf_mirror[7], 32'hB);

    // x0
    lv = 1; lrd = 0; ldd = 32'h55;
    cycle();
    chk("x0_ld_rw", rf_rw, 0); chk("x0_ld_cnt", ld_count, 0);
    idle_in(); av = 1; ard = 0; ad = 32'h66;
    #1; chk("x0_alu_ready", alu_ready, 1);
    cycle();
    chk("x0_alu_rw", rf_rw, 0);

    // reset mid-operation with three buffered loads
    for (int i = 0; i < 3; i++) begin
      av = 1; ard = 5'(1 + i); ad = i; lv = 1; lrd = 5'(9 + i); ldd = 32'h300 + i;
      cycle();
    end
    chk("mid_cnt3", ld_count, 3);
    idle_in(); reset = 0;
    #1; chk("mid_cnt0", ld_count, 0);
    cycle();
    reset = 1;
    nw = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (rf_rw) nw++;
    end
    chk("mid_nowrite", nw, 0);

    // randomized traffic
    idle_in(); acc = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!av || acc) begin
        av = 1'($urandom_range(0, 1)); ard = 5'($urandom_range(0, 7)); ad = $urandom;
      end
      lv = ($urandom_range(0, 2) != 0); lrd = 5'($urandom_range(0, 7)); ldd = $urandom;
      reset = ($urandom_range(0, 99) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end
endmodule
